// File: rtl/day9_pkg.sv
`default_nettype none
// ============================================================================
// Module      : day9_pkg
// Description : Shared types and default sizing for the day9 pair scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package day9_pkg;

    localparam int DEFAULT_W       = 17;
    localparam int DEFAULT_DEPTH   = 512;
    localparam int DEFAULT_LATENCY = 6;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [DEFAULT_W-1:0] x;
        logic [DEFAULT_W-1:0] y;
    } point_t;

endpackage : day9_pkg
`default_nettype wire

// File: rtl/day9_point_buffer.sv
`default_nettype none
// ============================================================================
// Module      : day9_point_buffer
// Description : Point store, one write port and two combinational read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module day9_point_buffer
    import day9_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clock,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [2*W-1:0]           wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_a,
    output logic [2*W-1:0]           rd_data_a,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_b,
    output logic [2*W-1:0]           rd_data_b
);

    logic [2*W-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = r_mem[rd_addr_a];
    assign rd_data_b = r_mem[rd_addr_b];

endmodule : day9_point_buffer
`default_nettype wire

// File: rtl/day9_pair_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : day9_pair_scheduler
// Description : Buffers a point list, issues every unordered pair to an area
//               pipeline and tracks the largest returned area.
//               Optional pair_count output enabled by DAY9_PAIR_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module day9_pair_scheduler
    import day9_pkg::*;
#(
    parameter int W       = DEFAULT_W,
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [W-1:0]              in_x,
    input  logic [W-1:0]              in_y,
    input  logic                      in_last,
    output logic                      pair_valid,
    output logic [W-1:0]              pair_ax,
    output logic [W-1:0]              pair_ay,
    output logic [W-1:0]              pair_bx,
    output logic [W-1:0]              pair_by,
    input  logic                      area_valid,
    input  logic [2*W-1:0]            area_in,
    output logic [2*W-1:0]            max_area,
    output logic                      done,
    output logic                      overflow,
`ifdef DAY9_PAIR_COUNT_EN
    output logic [2*$clog2(DEPTH):0]  pair_count,
`endif
    input  logic                      clear
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = 2*c_aw + 1;

    localparam logic [1:0] c_st_load  = ST_LOAD;
    localparam logic [1:0] c_st_issue = ST_ISSUE;
    localparam logic [1:0] c_st_drain = ST_DRAIN;
    localparam logic [1:0] c_st_done  = ST_DONE;

    localparam logic [c_aw:0]   c_cnt_one = (c_aw+1)'(1);
    localparam logic [c_aw:0]   c_cnt_two = (c_aw+1)'(2);
    localparam logic [c_aw-1:0] c_idx_one = c_aw'(1);
    localparam logic [c_aw-1:0] c_idx_two = c_aw'(2);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || LATENCY < 0) begin : g_bad_param
        $error("day9_pair_scheduler: DEPTH must be a power of two >= 4, LATENCY >= 0");
    end

    logic [1:0]      r_state;
    logic [c_aw:0]   r_count;
    logic [c_aw-1:0] r_i;
    logic [c_aw-1:0] r_j;
    logic [c_cw-1:0] r_issued;
    logic [c_cw-1:0] r_recv;
    logic [2*W-1:0]  r_max;
    logic            r_overflow;
    logic            r_done;
    logic            r_pair_valid;
    logic [W-1:0]    r_ax, r_ay, r_bx, r_by;

    logic            w_accept;
    logic            w_room;
    logic            w_last_j;
    logic            w_last_i;
    logic            w_count_en;
    logic [c_cw-1:0] w_recv_next;
    logic [2*W-1:0]  w_rd_a;
    logic [2*W-1:0]  w_rd_b;

    // count never exceeds DEPTH, so its MSB alone flags a full buffer
    assign w_room      = ~r_count[c_aw];
    assign w_accept    = in_valid && (r_state == c_st_load);
    assign w_last_j    = ({1'b0, r_j} == (r_count - c_cnt_one));
    assign w_last_i    = ({1'b0, r_i} == (r_count - c_cnt_two));
    assign w_count_en  = area_valid && (r_state == c_st_issue || r_state == c_st_drain);
    assign w_recv_next = r_recv + c_cw'(w_count_en);

    day9_point_buffer #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_buffer (
        .clock     (clock),
        .wr_en     (w_accept && w_room),
        .wr_addr   (r_count[c_aw-1:0]),
        .wr_data   ({in_x, in_y}),
        .rd_addr_a (r_i),
        .rd_data_a (w_rd_a),
        .rd_addr_b (r_j),
        .rd_data_b (w_rd_b)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_st_load;
            r_count      <= '0;
            r_i          <= '0;
            r_j          <= '0;
            r_issued     <= '0;
            r_recv       <= '0;
            r_max        <= '0;
            r_overflow   <= 1'b0;
            r_done       <= 1'b0;
            r_pair_valid <= 1'b0;
            r_ax         <= '0;
            r_ay         <= '0;
            r_bx         <= '0;
            r_by         <= '0;
        end else begin
            r_done       <= 1'b0;
            r_pair_valid <= 1'b0;
            if (area_valid && (area_in > r_max)) begin
                r_max <= area_in;
            end
            r_recv <= w_recv_next;

            case (r_state)
                c_st_load: begin
                    if (w_accept) begin
                        if (w_room) begin
                            r_count <= r_count + c_cnt_one;
                        end else begin
                            r_overflow <= 1'b1;
                        end
                        // any prior point means at least two in total
                        if (in_last) begin
                            if (r_count != '0) begin
                                r_state <= c_st_issue;
                                r_i     <= '0;
                                r_j     <= c_idx_one;
                            end else begin
                                r_state <= c_st_done;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
                c_st_issue: begin
                    r_pair_valid <= 1'b1;
                    {r_ax, r_ay} <= w_rd_a;
                    {r_bx, r_by} <= w_rd_b;
                    r_issued     <= r_issued + c_cw'(1);
                    if (w_last_j) begin
                        if (w_last_i) begin
                            r_state <= c_st_drain;
                        end else begin
                            r_i <= r_i + c_idx_one;
                            r_j <= r_i + c_idx_two;
                        end
                    end else begin
                        r_j <= r_j + c_idx_one;
                    end
                end
                c_st_drain: begin
                    if (w_recv_next == r_issued) begin
                        r_state <= c_st_done;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    if (clear) begin
                        r_state    <= c_st_load;
                        r_count    <= '0;
                        r_issued   <= '0;
                        r_recv     <= '0;
                        r_max      <= '0;
                        r_overflow <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign in_ready   = (r_state == c_st_load);
    assign pair_valid = r_pair_valid;
    assign pair_ax    = r_ax;
    assign pair_ay    = r_ay;
    assign pair_bx    = r_bx;
    assign pair_by    = r_by;
    assign max_area   = r_max;
    assign done       = r_done;
    assign overflow   = r_overflow;
`ifdef DAY9_PAIR_COUNT_EN
    assign pair_count = r_issued;
`endif

endmodule : day9_pair_scheduler
`default_nettype wire

// File: tb/tb_day9_pair_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_day9_pair_scheduler
// Description : Scoreboard bench for day9_pair_scheduler with a latency-6
//               rectangle-area model (DEPTH=512 and DEPTH=4 instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_day9_pair_scheduler;

    localparam int W   = 17;
    localparam int LAT = 6;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic           in_valid [2];
    logic           in_ready [2];
    logic [W-1:0]   in_x [2];
    logic [W-1:0]   in_y [2];
    logic           in_last [2];
    logic           pair_valid [2];
    logic [W-1:0]   pair_ax [2];
    logic [W-1:0]   pair_ay [2];
    logic [W-1:0]   pair_bx [2];
    logic [W-1:0]   pair_by [2];
    logic           area_valid [2];
    logic [2*W-1:0] area_in [2];
    logic [2*W-1:0] max_area [2];
    logic           done [2];
    logic           overflow [2];
    logic           clear [2];
`ifdef DAY9_PAIR_COUNT_EN
    logic [18:0]    pc0;
    logic [4:0]     pc1;
`endif

    day9_pair_scheduler #(.W(W), .DEPTH(512), .LATENCY(LAT)) dut0 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_x(in_x[0]), .in_y(in_y[0]), .in_last(in_last[0]),
        .pair_valid(pair_valid[0]),
        .pair_ax(pair_ax[0]), .pair_ay(pair_ay[0]), .pair_bx(pair_bx[0]), .pair_by(pair_by[0]),
        .area_valid(area_valid[0]), .area_in(area_in[0]), .max_area(max_area[0]),
        .done(done[0]), .overflow(overflow[0]),
`ifdef DAY9_PAIR_COUNT_EN
        .pair_count(pc0),
`endif
        .clear(clear[0])
    );

    day9_pair_scheduler #(.W(W), .DEPTH(4), .LATENCY(LAT)) dut1 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_x(in_x[1]), .in_y(in_y[1]), .in_last(in_last[1]),
        .pair_valid(pair_valid[1]),
        .pair_ax(pair_ax[1]), .pair_ay(pair_ay[1]), .pair_bx(pair_bx[1]), .pair_by(pair_by[1]),
        .area_valid(area_valid[1]), .area_in(area_in[1]), .max_area(max_area[1]),
        .done(done[1]), .overflow(overflow[1]),
`ifdef DAY9_PAIR_COUNT_EN
        .pair_count(pc1),
`endif
        .clear(clear[1])
    );

    int vectors = 0;
    int miscompares = 0;

    logic [4*W-1:0] exp_q [$];
    logic [2*W-1:0] exp_max;
    int             exp_pairs;
    int             issued_seen [2];
    int             done_seen [2];
    logic           pv [2][LAT];
    logic [2*W-1:0] pa [2][LAT];
    logic [W-1:0]   px [$];
    logic [W-1:0]   py [$];

    function automatic logic [2*W-1:0] rect_area(input logic [W-1:0] ax, ay, bx, by);
        logic [2*W-1:0] dx, dy;
        dx = (ax > bx) ? {{W{1'b0}}, ax - bx} : {{W{1'b0}}, bx - ax};
        dy = (ay > by) ? {{W{1'b0}}, ay - by} : {{W{1'b0}}, by - ay};
        return (dx + 1) * (dy + 1);
    endfunction

    task automatic flush_model();
        for (int g = 0; g < 2; g++) begin
            for (int k = 0; k < LAT; k++) begin
                pv[g][k] = 1'b0;
                pa[g][k] = '0;
            end
            area_valid[g] = 1'b0;
            area_in[g]    = '0;
        end
        exp_q.delete();
    endtask

    // One clock: sample DUT at negedge, pop scoreboard, advance the area model.
    task automatic tick();
        logic [4*W-1:0] e;
        @(negedge clock);
        for (int g = 0; g < 2; g++) begin
            if (done[g]) done_seen[g]++;
            if (pair_valid[g]) begin
                issued_seen[g]++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL pair_extra dut%0d: got %h, expected none", g,
                             {pair_ax[g], pair_ay[g], pair_bx[g], pair_by[g]});
                end else begin
                    e = exp_q.pop_front();
                    if ({pair_ax[g], pair_ay[g], pair_bx[g], pair_by[g]} !== e) begin
                        miscompares++;
                        $display("FAIL pair_order dut%0d: got %h, expected %h", g,
                                 {pair_ax[g], pair_ay[g], pair_bx[g], pair_by[g]}, e);
                    end
                end
            end
            area_valid[g] = pv[g][LAT-1];
            area_in[g]    = pa[g][LAT-1];
            for (int k = LAT-1; k > 0; k--) begin
                pv[g][k] = pv[g][k-1];
                pa[g][k] = pa[g][k-1];
            end
            pv[g][0] = pair_valid[g];
            pa[g][0] = rect_area(pair_ax[g], pair_ay[g], pair_bx[g], pair_by[g]);
        end
    endtask

    task automatic send_list(input int g, input int depth);
        int n, m;
        n = px.size();
        m = (n < depth) ? n : depth;
        exp_max = '0;
        exp_pairs = 0;
        issued_seen[g] = 0;
        for (int i = 0; i < m; i++) begin
            for (int j = i + 1; j < m; j++) begin
                exp_q.push_back({px[i], py[i], px[j], py[j]});
                exp_pairs++;
                if (rect_area(px[i], py[i], px[j], py[j]) > exp_max)
                    exp_max = rect_area(px[i], py[i], px[j], py[j]);
            end
        end
        vectors++;
        if (in_ready[g] !== 1'b1) begin
            miscompares++;
            $display("FAIL in_ready_load dut%0d: got %b, expected 1", g, in_ready[g]);
        end
        for (int k = 0; k < n; k++) begin
            in_valid[g] = 1'b1;
            in_x[g]     = px[k];
            in_y[g]     = py[k];
            in_last[g]  = (k == n - 1);
            tick();
        end
        in_valid[g] = 1'b0;
        in_last[g]  = 1'b0;
    endtask

    task automatic wait_done(input int g, input int start, input int budget);
        int t = 0;
        while (done_seen[g] == start && t < budget) begin
            tick();
            t++;
        end
        vectors++;
        if (done_seen[g] == start) begin
            miscompares++;
            $display("FAIL done_timeout dut%0d: no done after %0d cycles", g, budget);
        end
    endtask

    task automatic do_clear(input int g);
        clear[g] = 1'b1;
        tick();
        clear[g] = 1'b0;
    endtask

    task automatic set_example();
        px = '{17'd7, 17'd11, 17'd11, 17'd9, 17'd9, 17'd2, 17'd2, 17'd7};
        py = '{17'd1, 17'd1,  17'd7,  17'd7, 17'd5, 17'd5, 17'd3, 17'd3};
    endtask

    task automatic test_reset();
        for (int g = 0; g < 2; g++) begin
            in_valid[g] = 1'b0; in_last[g] = 1'b0; clear[g] = 1'b0;
            in_x[g] = '0; in_y[g] = '0;
            issued_seen[g] = 0; done_seen[g] = 0;
        end
        flush_model();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        for (int g = 0; g < 2; g++) begin
            vectors++;
            if ({pair_valid[g], done[g], overflow[g], max_area[g],
                 pair_ax[g], pair_ay[g], pair_bx[g], pair_by[g]} !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs dut%0d: pv=%b done=%b ovf=%b max=%0d", g,
                         pair_valid[g], done[g], overflow[g], max_area[g]);
            end
        end
        reset_n = 1'b1;
        tick();
        for (int g = 0; g < 2; g++) begin
            vectors++;
            if (in_ready[g] !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_ready dut%0d: got %b, expected 1", g, in_ready[g]);
            end
        end
    endtask

    task automatic test_example(input logic expect_clean);
        int start = done_seen[0];
        set_example();
        send_list(0, 512);
        wait_done(0, start, 400);
        vectors++;
        if (max_area[0] !== 34'd50 || exp_max !== 34'd50) begin
            miscompares++;
            $display("FAIL example_max: got %0d, expected 50", max_area[0]);
        end
        vectors++;
        if (issued_seen[0] != 28 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL example_pairs: got %0d issued, expected 28 (%0d unissued)",
                     issued_seen[0], exp_q.size());
        end
`ifdef DAY9_PAIR_COUNT_EN
        vectors++;
        if (pc0 !== 19'd28) begin
            miscompares++;
            $display("FAIL example_pair_count: got %0d, expected 28", pc0);
        end
`endif
        repeat (4) tick();
        vectors++;
        if (done_seen[0] != start + 1 || in_ready[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL example_done_once: got %0d pulses ready=%b, expected 1 pulse ready=0",
                     done_seen[0] - start, in_ready[0]);
        end
        if (expect_clean) begin
            vectors++;
            if (overflow[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL example_overflow: got %b, expected 0", overflow[0]);
            end
        end
    endtask

    task automatic test_clear_rerun();
        do_clear(0);
        vectors++;
        if (max_area[0] !== '0 || overflow[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_state: max=%0d ovf=%b ready=%b, expected 0/0/1",
                     max_area[0], overflow[0], in_ready[0]);
        end
        test_example(1'b1);
    endtask

    task automatic test_single_point();
        int start;
        do_clear(0);
        start = done_seen[0];
        px = '{17'd5};
        py = '{17'd6};
        send_list(0, 512);
        vectors++;
        if (done_seen[0] != start + 1) begin
            miscompares++;
            $display("FAIL single_done: got %0d pulses on accept, expected 1", done_seen[0] - start);
        end
        repeat (LAT + 2) tick();
        vectors++;
        if (issued_seen[0] != 0 || max_area[0] !== '0) begin
            miscompares++;
            $display("FAIL single_idle: got %0d pairs max=%0d, expected 0 pairs max=0",
                     issued_seen[0], max_area[0]);
        end
    endtask

    task automatic test_two_points(input logic do_clr);
        int start;
        if (do_clr) do_clear(0);
        start = done_seen[0];
        px = '{17'd0, 17'd3};
        py = '{17'd0, 17'd4};
        send_list(0, 512);
        wait_done(0, start, 100);
        vectors++;
        if (max_area[0] !== 34'd20 || issued_seen[0] != 1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL two_points: got max=%0d pairs=%0d, expected max=20 pairs=1",
                     max_area[0], issued_seen[0]);
        end
    endtask

    task automatic test_overflow();
        int start = done_seen[1];
        px = '{17'd1, 17'd4, 17'd0, 17'd3, 17'd20, 17'd8};
        py = '{17'd1, 17'd2, 17'd5, 17'd3, 17'd30, 17'd0};
        send_list(1, 4);
        vectors++;
        if (overflow[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_flag: got %b, expected 1", overflow[1]);
        end
        wait_done(1, start, 100);
        vectors++;
        if (issued_seen[1] != 6 || exp_q.size() != 0 || max_area[1] !== exp_max) begin
            miscompares++;
            $display("FAIL overflow_pairs: got %0d pairs max=%0d, expected 6 pairs max=%0d",
                     issued_seen[1], max_area[1], exp_max);
        end
`ifdef DAY9_PAIR_COUNT_EN
        vectors++;
        if (pc1 !== 5'd6) begin
            miscompares++;
            $display("FAIL overflow_pair_count: got %0d, expected 6", pc1);
        end
`endif
    endtask

    task automatic test_reset_mid_issue();
        do_clear(0);
        set_example();
        send_list(0, 512);
        repeat (5) tick();
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({pair_valid[0], done[0], overflow[0], max_area[0],
             pair_ax[0], pair_ay[0], pair_bx[0], pair_by[0]} !== '0 || in_ready[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_async: pv=%b done=%b max=%0d ax=%0d ready=%b, expected zeros/ready=1",
                     pair_valid[0], done[0], max_area[0], pair_ax[0], in_ready[0]);
        end
        flush_model();
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        test_two_points(1'b0);
    endtask

    initial begin
        test_reset();
        test_example(1'b1);
        test_clear_rerun();
        test_single_point();
        test_two_points(1'b1);
        test_overflow();
        test_reset_mid_issue();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_day9_pair_scheduler
`default_nettype wire

// File: doc/day9_pair_scheduler.md
DAY9_PAIR_SCHEDULER -- requirements
Module: day9_pair_scheduler

Interface
REQ-001 Parameter W, default 17, coordinate width in bits.
REQ-002 Parameter DEPTH, default 512, point buffer capacity (power of two, >=4).
REQ-003 Parameter LATENCY, default 6, fixed latency of the downstream pairwise area pipeline in cycles.
REQ-004 clock  input  1  sole clock, all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  coordinate on in_x/in_y is offered.
REQ-007 in_ready  output  1  scheduler accepts the coordinate this cycle.
REQ-008 in_x, in_y  input  W each  point coordinates.
REQ-009 in_last  input  1  marks final point of the list, qualified by in_valid && in_ready.
REQ-010 pair_valid  output  1  a point pair is presented to the area pipeline.
REQ-011 pair_ax, pair_ay, pair_bx, pair_by  output  W each  pair coordinates.
REQ-012 area_valid  input  1  area pipeline result strobe.
REQ-013 area_in  input  2*W  area pipeline result.
REQ-014 max_area  output  2*W  largest area_in received in the current run.
REQ-015 done  output  1  one-cycle pulse when the run completes.
REQ-016 overflow  output  1  sticky, set if a point arrived while the buffer was full.
REQ-017 clear  input  1  restarts the run from DONE.

Function
REQ-018 FSM states SHALL be LOAD, ISSUE, DRAIN, DONE; reset state LOAD.
REQ-019 LOAD: in_ready=1; accepted points written to buffer[count], count increments; when count==DEPTH, points are dropped, in_ready stays 1, overflow set.
REQ-020 LOAD -> ISSUE on accepted in_last with total count (including this point) >=2; with count <2 -> DONE directly, max_area=0.
REQ-021 ISSUE SHALL present every unordered pair (i,j), 0<=i<j<count, exactly once, order i ascending then j ascending, one pair per cycle, pair_valid registered (first pair one cycle after ISSUE entry).
REQ-022 Issued-pair counter and received-result counter SHALL be 2*clog2(DEPTH)+1 bits, no wrap for any legal count.
REQ-023 ISSUE -> DRAIN after pair (count-2, count-1) is issued; pair_valid=0 outside ISSUE.
REQ-024 On each area_valid, max_area <= max(max_area, area_in), unsigned compare, in any state.
REQ-025 DRAIN -> DONE when received count equals issued count; done pulses exactly on the entry cycle of DONE.
REQ-026 A result arriving on the cycle the last pair issues SHALL be counted and compared (no lost update).
REQ-027 DONE: in_ready=0; clear -> LOAD, zeroing count, counters, max_area, overflow; clear ignored in other states.
REQ-028 in_valid ignored (in_ready=0) in ISSUE, DRAIN, DONE.

Reset
REQ-029 reset_n low SHALL immediately force: state LOAD, count 0, all counters 0, max_area 0, overflow 0, done 0, pair_valid 0, pair_* 0, in_ready 1 after deassertion.
REQ-030 Reset mid-ISSUE or mid-DRAIN SHALL abandon the run; late area_valid after reset is folded into max_area of the new run (bench must not rely on it).
REQ-031 Buffer contents need not be reset.

Configuration
REQ-032 Macro DAY9_PAIR_COUNT_EN defined: output pair_count (2*clog2(DEPTH)+1 bits) SHALL equal issued pairs, valid when done pulses, held until clear; undefined: port absent, no counter beyond REQ-022 logic.

Structure
REQ-033 Shared package day9_pkg SHALL hold state enum, point struct {x,y}, default W/DEPTH/LATENCY constants.
REQ-034 Point buffer SHALL be a sub-module day9_point_buffer (one write, two combinational read ports).

Verification
REQ-035 Points (7,1)(11,1)(11,7)(9,7)(9,5)(2,5)(2,3)(7,3), last on 8th, reference area model latency 6 -> 28 pairs issued, done once, max_area=50.
REQ-036 Single point with in_last -> done next cycle, max_area=0, no pair_valid.
REQ-037 Two points (0,0)(3,4) -> exactly one pair (0,0,3,4), max_area=20.
REQ-038 DEPTH=4, six points sent -> overflow=1, 6 pairs issued from first four points.
REQ-039 reset_n pulsed low mid-ISSUE -> outputs at reset values asynchronously, next run of REQ-037 gives max_area=20.
REQ-040 clear in DONE then rerun REQ-035 -> max_area=50, overflow=0; with DAY9_PAIR_COUNT_EN pair_count=28.
